// File: rtl/waffle_pkg.sv
// Shared types and defaults for the image loader.
package waffle_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        KICK = 2'd2,
        WAIT = 2'd3
    } loader_state_t;

    localparam int DEF_IMG_ROWS = 32;
    localparam int DEF_IMG_COLS = 32;

endpackage

// File: rtl/loader_addr_gen.sv
// Row/column pixel counters and the raster-order memory address they imply.
module loader_addr_gen
    import waffle_pkg::*;
#(
    parameter int    IMG_ROWS  = DEF_IMG_ROWS,
    parameter int    IMG_COLS  = DEF_IMG_COLS,
    parameter addr_t BASE_ADDR = '0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clear,
    input  logic  advance,
    output addr_t addr,
    output logic  is_final
);

    localparam int RW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int CW = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_wrap;

    assign col_wrap = (col_q == COL_MAX);
    assign is_final = (row_q == ROW_MAX) && col_wrap;
    assign addr     = BASE_ADDR + addr_t'(row_q) * addr_t'(IMG_COLS) + addr_t'(col_q);

    // Next counter values: clear wins, otherwise step one pixel in raster order.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/image_loader.sv
// Streams one frame of pixels into memory, kicks the solver, waits for it.
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN adds a running pixel checksum output.
//
// state | meaning
// IDLE  | no frame in progress, waiting for frame_start
// LOAD  | accepting pixels and writing them to memory
// KICK  | last pixel written, one-cycle solver_start
// WAIT  | solver owns memory until solver_complete
module image_loader
    import waffle_pkg::*;
#(
    parameter int    IMG_ROWS  = DEF_IMG_ROWS,
    parameter int    IMG_COLS  = DEF_IMG_COLS,
    parameter addr_t BASE_ADDR = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   frame_start,
    input  logic   in_valid,
    input  pixel_t in_data,
    input  logic   in_last,
    output logic   in_ready,
    output addr_t  mem_addr,
    output pixel_t mem_wdata,
    output logic   mem_we,
    output logic   solver_start,
    input  logic   solver_complete,
    output logic   frame_done,
    output logic   err
`ifdef IMAGE_LOADER_CHECKSUM_EN
    ,
    output pixel_t checksum
`endif
);

    loader_state_t state_q, state_d;

    logic   start_frame;
    logic   accept;
    logic   is_final;
    addr_t  gen_addr;

    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   mem_we_q, mem_we_d;
    addr_t  mem_addr_q, mem_addr_d;
    pixel_t mem_wdata_q, mem_wdata_d;

    loader_addr_gen #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_frame),
        .advance (accept),
        .addr    (gen_addr),
        .is_final(is_final)
    );

    // Next state and the control strobes that depend only on state.
    always_comb begin
        state_d      = state_q;
        start_frame  = 1'b0;
        in_ready     = 1'b0;
        solver_start = 1'b0;
        frame_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    start_frame = 1'b1;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                // The cycle after the final pixel is taken carries its write,
                // so LOAD lingers one cycle with in_ready low before KICK.
                in_ready = !done_q;
                if (done_q) begin
                    state_d = KICK;
                end
            end
            KICK: begin
                solver_start = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                if (solver_complete) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Write pipeline, end-of-load flag and sticky framing error.
    always_comb begin
        mem_we_d    = accept;
        mem_addr_d  = accept ? gen_addr : mem_addr_q;
        mem_wdata_d = accept ? in_data : mem_wdata_q;
        err_d       = err_q || (accept && (in_last != is_final));
        done_d      = start_frame ? 1'b0 : (done_q || (accept && is_final));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    pixel_t csum_q, csum_d;

    // Wrapping sum of the pixels accepted since the last frame_start.
    always_comb begin
        csum_d = csum_q;
        if (start_frame) begin
            csum_d = '0;
        end else if (accept) begin
            csum_d = csum_q + in_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule
